// File: rtl/cic_output_arbiter.sv
// -----------------------------------------------------------------------------
// cic_output_arbiter
//
// Merges NumChannels cic_decimator output streams onto one tagged output
// stream. Each channel has a one-word holding register. A single output
// register is refilled round-robin from the held words. Words pass through
// unmodified, and per-channel order is preserved.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous, active-low reset
//   in             : packed channel words, channel i at [i*WordLengthBits +: WordLengthBits]
//   in_valid       : per-channel valid
//   in_ready       : per-channel ready (independent of in_valid)
//   channel_enable : per-channel enable; disabled channels are drained and discarded
//   out            : arbitrated word (registered)
//   out_channel    : source channel of out (registered)
//   out_valid      : out/out_channel valid (registered)
//   out_ready      : downstream accepts the word
//
// ChannelIdBits must equal max(1, ceil(log2(NumChannels))).
// -----------------------------------------------------------------------------
module cic_output_arbiter #(
   parameter int NumChannels    = 4,
   parameter int WordLengthBits = 36,
   parameter int ChannelIdBits  = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NumChannels*WordLengthBits-1:0] in,
   input  logic [NumChannels-1:0]                in_valid,
   output logic [NumChannels-1:0]                in_ready,
   input  logic [NumChannels-1:0]                channel_enable,
   output logic [WordLengthBits-1:0]             out,
   output logic [ChannelIdBits-1:0]              out_channel,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   logic [WordLengthBits-1:0] hold_data_r [NumChannels];
   logic [NumChannels-1:0]    held_r;
   logic [ChannelIdBits-1:0]  last_grant_r;

   logic [NumChannels-1:0]    eligible_s;
   logic [NumChannels-1:0]    grant_s;
   logic [NumChannels-1:0]    accept_s;
   logic                      out_free_s;
   logic                      grant_valid_s;
   logic [ChannelIdBits-1:0]  grant_idx_s;
   logic                      hi_found_s;
   logic [ChannelIdBits-1:0]  hi_idx_s;
   logic                      lo_found_s;
   logic [ChannelIdBits-1:0]  lo_idx_s;

   // A held word of a disabled channel is never offered for output.
   assign eligible_s = held_r & channel_enable;
   assign out_free_s = !out_valid || out_ready;

   // A channel is ready when disabled (data discarded), empty, or being emptied by its grant.
   assign in_ready   = ~channel_enable | ~held_r | grant_s;
   assign accept_s   = in_valid & in_ready;

   // Round-robin pick. The first eligible channel above last_grant wins;
   // otherwise the lowest eligible channel wins (the wrap-around part of the modulo search).
   always_comb begin
      hi_found_s = 1'b0;
      hi_idx_s   = '0;
      lo_found_s = 1'b0;
      lo_idx_s   = '0;
      // Descending scan so that the last assignment is the lowest qualifying index.
      for (int i = NumChannels - 1; i >= 0; i--) begin
         if (eligible_s[i]) begin
            if (ChannelIdBits'(i) > last_grant_r) begin
               hi_found_s = 1'b1;
               hi_idx_s   = ChannelIdBits'(i);
            end else begin
               hi_found_s = hi_found_s;
            end
            lo_found_s = 1'b1;
            lo_idx_s   = ChannelIdBits'(i);
         end else begin
            lo_found_s = lo_found_s;
         end
      end
      if (hi_found_s) begin
         grant_idx_s = hi_idx_s;
      end else begin
         grant_idx_s = lo_idx_s;
      end
      grant_valid_s = out_free_s && lo_found_s;
   end

   // One-hot grant vector used by in_ready and the holding-register clear.
   always_comb begin
      grant_s = '0;
      for (int i = 0; i < NumChannels; i++) begin
         grant_s[i] = grant_valid_s && (grant_idx_s == ChannelIdBits'(i));
      end
   end

   // Output register and round-robin pointer. They load on a grant and empty when drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out          <= '0;
         out_channel  <= '0;
         out_valid    <= 1'b0;
         last_grant_r <= ChannelIdBits'(NumChannels - 1);
      end else if (out_free_s) begin
         if (grant_valid_s) begin
            out          <= hold_data_r[grant_idx_s];
            out_channel  <= grant_idx_s;
            out_valid    <= 1'b1;
            last_grant_r <= grant_idx_s;
         end else begin
            out_valid    <= 1'b0;
         end
      end
   end

   // Per-channel holding registers. A new accept on the granted channel
   // refills the register on the same edge, so a single streaming channel
   // runs at one word per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_r <= '0;
         for (int i = 0; i < NumChannels; i++) begin
            hold_data_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumChannels; i++) begin
            if (!channel_enable[i]) begin
               held_r[i] <= 1'b0;
            end else if (accept_s[i]) begin
               held_r[i]      <= 1'b1;
               hold_data_r[i] <= in[i*WordLengthBits +: WordLengthBits];
            end else if (grant_s[i]) begin
               held_r[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cic_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cic_output_arbiter
//
// Self-checking bench for cic_output_arbiter (4 channels, 36-bit words).
// A transaction-level reference model predicts in_ready and the output
// register every cycle. It keeps per-channel one-word slot queues, one
// output queue and a round-robin pointer. A per-channel scoreboard of
// accepted words checks ordering at every output transfer. Directed
// scenarios come first, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_cic_output_arbiter;

   localparam int N   = 4;
   localparam int W   = 36;
   localparam int IDB = 2;

   typedef struct {
      logic [W-1:0] w;
      int           ch;
   } item_t;

   logic             clk;
   logic             rst;
   logic [N*W-1:0]   in_bus;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [N-1:0]     channel_enable;
   logic [W-1:0]     out;
   logic [IDB-1:0]   out_channel;
   logic             out_valid;
   logic             out_ready;

   // stimulus values, applied to the DUT on the falling edge
   logic [N*W-1:0]   stim_din;
   logic [N-1:0]     stim_iv;
   logic [N-1:0]     stim_en;
   logic             stim_ordy;

   // reference model state
   logic [W-1:0]     slot [N][$];
   logic [W-1:0]     sb   [N][$];
   item_t            oq   [$];
   int               last;

   int               checks;
   int               errors;

   cic_output_arbiter #(
      .NumChannels   (N),
      .WordLengthBits(W),
      .ChannelIdBits (IDB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in            (in_bus),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .channel_enable(channel_enable),
      .out           (out),
      .out_channel   (out_channel),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         slot[i].delete();
         sb[i].delete();
      end
      oq.delete();
      last = N - 1;
   endtask

   task automatic rand_din();
      for (int i = 0; i < N; i++) begin
         stim_din[i*W +: W] = W'({$urandom(), $urandom()});
      end
   endtask

   // Reset pulse that starts on a falling edge; checks the asynchronous effect before any rising edge.
   task automatic do_reset();
      @(negedge clk);
      stim_iv  = '0;
      in_valid = '0;
      rst      = 1'b0;
      #1;
      check_val("rst_out_valid", 64'(out_valid), 64'(0));
      check_val("rst_out", 64'(out), 64'(0));
      check_val("rst_out_channel", 64'(out_channel), 64'(0));
      check_val("rst_in_ready", 64'(in_ready), 64'(4'hF));
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock cycle. The task drives the inputs, compares the DUT against
   // the model, advances the model and then waits for the rising edge.
   task automatic cycle();
      logic [N-1:0] exp_rdy;
      logic         free;
      logic         gv;
      int           g;
      int           c;
      item_t        it;
      logic [W-1:0] ew;
      @(negedge clk);
      in_bus         = stim_din;
      in_valid       = stim_iv;
      channel_enable = stim_en;
      out_ready      = stim_ordy;
      #1;
      free = (oq.size() == 0) || stim_ordy;
      gv   = 1'b0;
      g    = 0;
      for (int k = 1; k <= N; k++) begin
         c = (last + k) % N;
         if (!gv && slot[c].size() != 0 && stim_en[c]) begin
            gv = 1'b1;
            g  = c;
         end
      end
      gv = gv && free;
      for (int i = 0; i < N; i++) begin
         exp_rdy[i] = !stim_en[i] || (slot[i].size() == 0) || (gv && g == i);
      end
      check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
      check_val("out_valid", 64'(out_valid), 64'(oq.size() != 0));
      if (oq.size() != 0) begin
         check_val("out_data", 64'(out), 64'(oq[0].w));
         check_val("out_chan", 64'(out_channel), 64'(oq[0].ch));
         if (stim_ordy) begin
            ew = sb[oq[0].ch].pop_front();
            check_val("sb_order", 64'(out), 64'(ew));
            oq.delete(0);
         end
      end
      if (gv) begin
         it.w  = slot[g].pop_front();
         it.ch = g;
         oq.push_back(it);
         last  = g;
      end
      for (int i = 0; i < N; i++) begin
         if (!stim_en[i]) begin
            if (slot[i].size() != 0) begin
               slot[i].delete();
               sb[i].delete(sb[i].size() - 1);
            end
         end else if (stim_iv[i] && exp_rdy[i]) begin
            slot[i].push_back(stim_din[i*W +: W]);
            sb[i].push_back(stim_din[i*W +: W]);
         end
      end
      @(posedge clk);
   endtask

   initial begin
      int nexp;
      int saw2;
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      stim_din       = '0;
      stim_iv        = '0;
      stim_en        = 4'hF;
      stim_ordy      = 1'b1;
      in_bus         = '0;
      in_valid       = '0;
      channel_enable = 4'hF;
      out_ready      = 1'b1;
      model_reset();
      do_reset();

      // single channel: ch2 word 0x123, visible two edges after acceptance, for exactly one cycle
      stim_din[2*W +: W] = 36'h123;
      stim_iv            = 4'b0100;
      cycle();
      stim_iv = '0;
      cycle();
      #2;
      check_val("single_valid", 64'(out_valid), 64'(1));
      check_val("single_data", 64'(out), 64'(36'h123));
      check_val("single_chan", 64'(out_channel), 64'(2));
      cycle();
      #2;
      check_val("single_one_cycle", 64'(out_valid), 64'(0));

      // round-robin: all channels streaming, data = channel index
      do_reset();
      for (int i = 0; i < N; i++) begin
         stim_din[i*W +: W] = W'(i);
      end
      stim_iv   = 4'hF;
      stim_ordy = 1'b1;
      nexp      = 0;
      for (int n = 0; n < 12; n++) begin
         cycle();
         #2;
         if (nexp > 0 || out_valid) begin
            check_val("rr_valid", 64'(out_valid), 64'(1));
            check_val("rr_seq", 64'(out_channel), 64'(nexp % N));
            nexp++;
         end
      end
      check_val("rr_count", 64'(nexp), 64'(11));

      // backpressure: ten stalled cycles, then drain with no new inputs
      stim_ordy = 1'b0;
      for (int n = 0; n < 10; n++) begin
         rand_din();
         cycle();
      end
      #2;
      check_val("bp_in_ready", 64'(in_ready), 64'(0));
      check_val("bp_out_valid", 64'(out_valid), 64'(1));
      stim_ordy = 1'b1;
      stim_iv   = '0;
      for (int n = 0; n < 7; n++) begin
         cycle();
      end
      #2;
      check_val("bp_drained", 64'(out_valid), 64'(0));

      // disable: ch2 held behind ch0, then channel_enable = 1011
      do_reset();
      stim_din           = '0;
      stim_din[0*W +: W] = 36'hA0;
      stim_din[2*W +: W] = 36'hC2;
      stim_ordy          = 1'b0;
      stim_iv            = 4'b0101;
      cycle();
      stim_iv = '0;
      cycle();
      stim_en            = 4'b1011;
      stim_iv            = 4'b0100;
      stim_din[2*W +: W] = 36'hBAD;
      cycle();
      #2;
      check_val("dis_rdy2", 64'(in_ready[2]), 64'(1));
      stim_ordy          = 1'b1;
      stim_iv            = 4'b1100;
      stim_din[3*W +: W] = 36'h3D;
      saw2               = 0;
      for (int n = 0; n < 6; n++) begin
         cycle();
         stim_iv = 4'b0100;
         #2;
         if (out_valid && out_channel == 2'd2) saw2++;
      end
      check_val("dis_no_ch2", 64'(saw2), 64'(0));
      stim_en = 4'hF;
      stim_iv = '0;
      cycle();

      // mid-operation reset during traffic; first grant after release is lowest held channel
      stim_iv   = 4'hF;
      stim_ordy = 1'b1;
      for (int n = 0; n < 5; n++) begin
         rand_din();
         cycle();
      end
      do_reset();
      stim_iv = 4'b0110;
      rand_din();
      cycle();
      stim_iv = '0;
      cycle();
      #2;
      check_val("rst_first_valid", 64'(out_valid), 64'(1));
      check_val("rst_first_chan", 64'(out_channel), 64'(1));
      cycle();
      cycle();

      // randomized traffic with occasional enable changes
      for (int n = 0; n < 10000; n++) begin
         rand_din();
         stim_iv   = N'($urandom());
         stim_ordy = ($urandom_range(0, 9) < 7);
         stim_en   = ($urandom_range(0, 15) == 0) ? N'($urandom()) : 4'hF;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
